// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one CPU memory bus port between instruction fetch (I) and the
//           load/store unit (D), alternating under contention, with a bounded-wait
//           timeout that aborts hung bus transactions.
// Latency : a request seen in IDLE drives m_req from the next cycle. The ack is
//           combinational with m_ack, or raised on the timeout cycle.
// Backpr. : requesters hold req and fields until their ack; stall_f/stall_m
//           report the wait. One IDLE cycle always separates two grants.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ack); i_ack/i_rdata completion
//   d_req/d_we/d_addr/  data request (held until d_ack); d_ack/d_rdata completion
//   d_wdata/d_be
//   m_req/m_we/m_addr/  external bus master side; m_ack/m_rdata from the bus
//   m_wdata/m_be
//   stall_f, stall_m    requester waiting (drops in the ack cycle)
//   bus_err             accompanies i_ack/d_ack when the transaction timed out
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic            stall_f,
    output logic            stall_m,
    output logic            bus_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    // Counter value on the final permitted grant cycle (unused when TIMEOUT==0).
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] be_q, be_d;

    logic granted;
    logic to_hit;
    logic done;

    assign granted = (state_q != ST_IDLE);
    // A real m_ack on the last permitted cycle beats the timeout.
    assign to_hit  = granted && (TIMEOUT != 0) && (cnt_q == TO_LAST) && !m_ack;
    assign done    = granted && (m_ack || to_hit);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                // Under contention the side that did not go last wins.
                if (d_req && (!i_req || last_q == LAST_I)) begin
                    state_d = ST_GNT_D;
                    last_d  = LAST_D;
                    cnt_d   = '0;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    be_d    = d_be;
                end else if (i_req) begin
                    state_d = ST_GNT_I;
                    last_d  = LAST_I;
                    cnt_d   = '0;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    be_d    = '1;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (done) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_I;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Bus fields come only from the latched copies so requester edits mid-grant
    // cannot reach the bus.
    assign m_req   = granted;
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_be    = be_q;

    assign i_ack   = (state_q == ST_GNT_I) && done;
    assign d_ack   = (state_q == ST_GNT_D) && done;
    assign bus_err = to_hit;

    assign i_rdata = (i_ack && !to_hit) ? m_rdata : '0;
    assign d_rdata = (d_ack && !to_hit) ? m_rdata : '0;

    assign stall_f = i_req && !i_ack;
    assign stall_m = d_req && !d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        stall_f;
    logic        stall_m;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_bus_arbiter #(.AW(32), .DW(32), .TO_W(8), .TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_be    (d_be),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_be    (m_be),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .stall_f (stall_f),
        .stall_m (stall_m),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Move 1ns past the next rising edge; new inputs are applied here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change, before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_be = 0; m_ack = 0; m_rdata = 0;
        cyc(); cyc();
        reset = 1'b0;
        settle();
        check("rst m_req",   {31'd0, m_req},   32'd0);
        check("rst m_addr",  m_addr,           32'd0);
        check("rst m_we",    {31'd0, m_we},    32'd0);
        check("rst m_wdata", m_wdata,          32'd0);
        check("rst m_be",    {28'd0, m_be},    32'd0);
        check("rst acks",    {30'd0, i_ack, d_ack}, 32'd0);
        check("rst bus_err", {31'd0, bus_err}, 32'd0);
        check("rst rdata",   i_rdata | d_rdata, 32'd0);

        // Fetch at 0x100, bus acks on the third grant cycle.
        i_req = 1; i_addr = 32'h100;
        settle();
        check("t1 stall_f idle", {31'd0, stall_f}, 32'd1);
        check("t1 m_req idle",   {31'd0, m_req},   32'd0);
        cyc(); settle();
        check("t1 m_req",   {31'd0, m_req}, 32'd1);
        check("t1 m_addr",  m_addr,         32'h100);
        check("t1 m_we",    {31'd0, m_we},  32'd0);
        check("t1 m_be",    {28'd0, m_be},  32'hF);
        check("t1 stall_f", {31'd0, stall_f}, 32'd1);
        cyc(); settle();
        check("t1 no ack yet", {31'd0, i_ack}, 32'd0);
        cyc();
        m_ack = 1; m_rdata = 32'hDEADBEEF;
        settle();
        check("t1 i_ack",     {31'd0, i_ack},   32'd1);
        check("t1 i_rdata",   i_rdata,          32'hDEADBEEF);
        check("t1 stall_f ack", {31'd0, stall_f}, 32'd0);
        check("t1 bus_err",   {31'd0, bus_err}, 32'd0);
        cyc();
        m_ack = 0; i_req = 0;
        settle();
        check("t1 m_req after", {31'd0, m_req}, 32'd0);
        check("t1 i_rdata after", i_rdata, 32'd0);

        // Contention: D, I, D, I with one IDLE cycle between grants.
        do_reset();
        i_req = 1; i_addr = 32'h300; d_req = 1; d_addr = 32'h200; d_we = 0;
        m_rdata = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) begin
            logic is_d;
            is_d = (k % 2 == 0);
            settle();
            check($sformatf("t2 idle m_req %0d", k), {31'd0, m_req}, 32'd0);
            cyc();
            m_ack = 1;
            settle();
            check($sformatf("t2 m_req %0d", k),  {31'd0, m_req}, 32'd1);
            check($sformatf("t2 m_addr %0d", k), m_addr, is_d ? 32'h200 : 32'h300);
            check($sformatf("t2 acks %0d", k),   {30'd0, d_ack, i_ack},
                  is_d ? 32'd2 : 32'd1);
            cyc();
            m_ack = 0;
        end
        i_req = 0; d_req = 0;

        // Store with requester fields changed mid-grant.
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011;
        cyc(); settle();
        check("t3 m_we",    {31'd0, m_we}, 32'd1);
        check("t3 m_addr",  m_addr,        32'h2000);
        d_we = 0; d_addr = 32'hFFFF; d_wdata = 0; d_be = 4'hF;
        settle();
        check("t3 hold m_we",    {31'd0, m_we}, 32'd1);
        check("t3 hold m_addr",  m_addr,        32'h2000);
        check("t3 hold m_wdata", m_wdata,       32'h12345678);
        check("t3 hold m_be",    {28'd0, m_be}, 32'h3);
        check("t3 stall_m",      {31'd0, stall_m}, 32'd1);
        cyc();
        m_ack = 1;
        settle();
        check("t3 d_ack",   {31'd0, d_ack},   32'd1);
        check("t3 stall_m ack", {31'd0, stall_m}, 32'd0);
        check("t3 bus_err", {31'd0, bus_err}, 32'd0);
        cyc();
        m_ack = 0; d_req = 0;

        // Timeout: four grant cycles without m_ack, then one with m_ack on cycle 4.
        d_we = 0; d_addr = 32'h40; d_req = 1; m_rdata = 32'hAAAA5555;
        settle();
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 3; c++) begin
                cyc(); settle();
                check($sformatf("t4 r%0d m_req c%0d", r, c), {31'd0, m_req}, 32'd1);
                check($sformatf("t4 r%0d d_ack c%0d", r, c), {31'd0, d_ack}, 32'd0);
            end
            cyc();
            m_ack = (r == 1);
            settle();
            check($sformatf("t4 r%0d m_req c4", r), {31'd0, m_req}, 32'd1);
            check($sformatf("t4 r%0d d_ack c4", r), {31'd0, d_ack}, 32'd1);
            check($sformatf("t4 r%0d bus_err", r), {31'd0, bus_err}, (r == 0) ? 32'd1 : 32'd0);
            check($sformatf("t4 r%0d d_rdata", r), d_rdata, (r == 0) ? 32'd0 : 32'hAAAA5555);
            cyc();
            m_ack = 0; d_req = 0;
            settle();
            check($sformatf("t4 r%0d m_req end", r), {31'd0, m_req}, 32'd0);
            d_req = 1;
        end
        d_req = 0;

        // Reset mid fetch grant aborts silently; then D wins contention.
        cyc();
        i_req = 1; i_addr = 32'h500;
        cyc(); settle();
        check("t5 m_req gnt", {31'd0, m_req}, 32'd1);
        reset = 1;
        settle();
        check("t5 no i_ack", {31'd0, i_ack}, 32'd0);
        cyc();
        reset = 0; d_req = 1; d_addr = 32'h600; d_we = 0;
        settle();
        check("t5 m_req dropped", {31'd0, m_req}, 32'd0);
        check("t5 no ack/err", {29'd0, i_ack, d_ack, bus_err}, 32'd0);
        cyc(); settle();
        check("t5 D first addr", m_addr, 32'h600);
        check("t5 D first ack",  {30'd0, d_ack, i_ack}, 32'd0);
        m_ack = 1;
        settle();
        check("t5 d_ack", {30'd0, d_ack, i_ack}, 32'd2);
        cyc();
        m_ack = 0; i_req = 0; d_req = 0;

        // m_ack while IDLE with nothing requested is ignored.
        cyc();
        m_ack = 1; m_rdata = 32'h77;
        settle();
        check("t6 acks",  {30'd0, i_ack, d_ack}, 32'd0);
        check("t6 rdata", i_rdata | d_rdata, 32'd0);
        check("t6 bus_err", {31'd0, bus_err}, 32'd0);
        cyc(); settle();
        check("t6 m_req", {31'd0, m_req}, 32'd0);
        m_ack = 0; i_req = 1; i_addr = 32'h700;
        cyc(); settle();
        check("t6 then grant", {31'd0, m_req}, 32'd1);
        check("t6 then addr",  m_addr, 32'h700);
        check("t6 then no ack", {31'd0, i_ack}, 32'd0);
        i_req = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
